caliptra_prim_edn_rsp: RTL

Single-clock EDN endpoint responder. It serves 32-bit entropy words on an edn_pkg endpoint interface, unpacked from wider genbits blocks (e.g. 128-bit CSRNG output) delivered over a valid/ready upstream port. It is the answering side of the EDN req/ack handshake. Block-level benches use it as an EDN model, and lightweight subsystems without a full EDN use it as a local EDN.

---
 rtl/caliptra_prim_edn_rsp_pkg.sv | 23 ++
 rtl/edn_pkg.sv | 23 ++
 rtl/caliptra_prim_edn_rsp.sv | 119 +++++++++++
 3 files changed

// File: rtl/caliptra_prim_edn_rsp_pkg.sv
// ============================================================================
// caliptra_prim_edn_rsp_pkg : shared types and helpers for the EDN responder
// Rev 1.0
// ============================================================================
`default_nettype none

package caliptra_prim_edn_rsp_pkg;

  localparam int unsigned EdnWordW = edn_pkg::ENDPOINT_BUS_WIDTH;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StServe = 1'b1
  } edn_rsp_state_e;

  // A single-word block still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edn_pkg.sv
// ============================================================================
// edn_pkg : EDN endpoint request/response bus types
// Rev 1.0
// ============================================================================
`default_nettype none

package edn_pkg;

  parameter int unsigned ENDPOINT_BUS_WIDTH = 32;

  typedef struct packed {
    logic edn_req;
  } edn_req_t;

  typedef struct packed {
    logic                          edn_ack;
    logic                          edn_fips;
    logic [ENDPOINT_BUS_WIDTH-1:0] edn_bus;
  } edn_rsp_t;

endpackage

`default_nettype wire

// File: rtl/caliptra_prim_edn_rsp.sv
// ============================================================================
// caliptra_prim_edn_rsp : EDN endpoint responder serving 32-bit words
//                         unpacked from wide genbits blocks
// Rev 1.0
// ============================================================================
`default_nettype none

module caliptra_prim_edn_rsp
  import edn_pkg::*;
  import caliptra_prim_edn_rsp_pkg::*;
#(
  parameter int unsigned GenBitsW = 128,
  parameter bit          RepCheck = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                genbits_valid_i,
  output logic                genbits_ready_o,
  input  logic [GenBitsW-1:0] genbits_bus_i,
  input  logic                genbits_fips_i,
  input  edn_req_t            edn_i,
  output edn_rsp_t            edn_o,
  output logic [15:0]         words_served_o,
  output logic                rep_err_o
);

  localparam int unsigned NumWords = GenBitsW / EdnWordW;
  localparam int unsigned IdxW     = idx_width(NumWords);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  edn_rsp_state_e                     state_q;
  logic [NumWords-1:0][EdnWordW-1:0]  buf_q;
  logic [IdxW-1:0]                    idx_q;
  logic                               fips_q;
  logic                               ack_q;
  logic                               fips_out_q;
  logic [EdnWordW-1:0]                bus_q;
  logic [15:0]                        cnt_q;

  logic rep_hit;
  logic hs;
  logic load;
  logic ack_fire;

  // Ready is masked during reset so upstream never sees a spurious handshake.
  assign genbits_ready_o = rst_ni & enable_i & (state_q == StEmpty);
  assign hs              = genbits_valid_i & genbits_ready_o;
  assign load            = hs & ~rep_hit;
  assign ack_fire        = (state_q == StServe) & edn_i.edn_req & enable_i & ~ack_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEmpty;
      buf_q      <= '0;
      idx_q      <= '0;
      fips_q     <= 1'b0;
      ack_q      <= 1'b0;
      fips_out_q <= 1'b0;
      bus_q      <= '0;
      cnt_q      <= '0;
    end else begin
      ack_q <= ack_fire;
      if (ack_fire) begin
        bus_q      <= buf_q[idx_q];
        fips_out_q <= fips_q;
        if (cnt_q != 16'hFFFF) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      if (!enable_i) begin
        state_q <= StEmpty;
        idx_q   <= '0;
      end else if (load) begin
        buf_q   <= genbits_bus_i;
        fips_q  <= genbits_fips_i;
        idx_q   <= '0;
        state_q <= StServe;
      end else if (ack_fire) begin
        idx_q <= idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_q <= StEmpty;
        end
      end
    end
  end

  if (RepCheck) begin : gen_rep_chk
    logic [GenBitsW-1:0] prev_q;
    logic                prev_valid_q;
    logic                rep_err_q;

    assign rep_hit   = prev_valid_q && (genbits_bus_i == prev_q);
    assign rep_err_o = rep_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q       <= '0;
        prev_valid_q <= 1'b0;
        rep_err_q    <= 1'b0;
      end else begin
        rep_err_q <= hs & rep_hit;
        if (load) begin
          prev_q       <= genbits_bus_i;
          prev_valid_q <= 1'b1;
        end
      end
    end
  end else begin : gen_no_rep_chk
    assign rep_hit   = 1'b0;
    assign rep_err_o = 1'b0;
  end

  assign edn_o          = '{edn_ack: ack_q, edn_fips: fips_out_q, edn_bus: bus_q};
  assign words_served_o = cnt_q;

endmodule

`default_nettype wire
